// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction fetch sequencer: requests a word at pc,
// holds it for decode, loads new_pc on each decode handshake, and flags memory timeouts.
module pc_fetch_sequencer #(
    parameter logic [29:0] RESET_PC = 30'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] new_pc,
    output logic [29:0] pc,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        fetch_err,
    output logic [31:0] fetch_count
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, OUT, ERR} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          capture, handshake;

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        capture   = 1'b0;
        handshake = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                // an ack in the last allowed cycle beats the timeout
                if (imem_ack) begin
                    capture   = 1'b1;
                    timer_nxt = '0;
                    state_nxt = OUT;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_nxt = ERR;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            OUT: begin
                if (inst_ready) begin
                    handshake = 1'b1;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            pc          <= RESET_PC;
            inst        <= 32'h0;
            fetch_count <= 32'h0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            if (capture)   inst <= imem_rdata;
            if (handshake) pc   <= new_pc;
            fetch_count <= fetch_count + {31'b0, handshake};
        end
    end

    // ERR is only left through reset, so the sticky flag is just the state decode
    assign imem_req   = (state == REQ);
    assign inst_valid = (state == OUT);
    assign fetch_err  = (state == ERR);
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed vector table for pc_fetch_sequencer plus a hand sequence for fetch_count wrap.
module tb_pc_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [29:0] new_pc = '0;
    logic [29:0] pc;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        fetch_err;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_bad = 0;

    pc_fetch_sequencer #(.RESET_PC(30'h0), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .new_pc(new_pc), .pc(pc), .imem_req(imem_req),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .fetch_err(fetch_err), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic [29:0] new_pc;
        logic [29:0] e_pc;
        logic        e_req;
        logic [31:0] e_inst;
        logic        e_valid;
        logic        e_err;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic v(input logic r, input logic a, input logic [31:0] rd, input logic rdy,
                     input logic [31:0] np, input logic [31:0] epc, input logic ereq,
                     input logic [31:0] einst, input logic evld, input logic eerr,
                     input logic [31:0] ecnt);
        vec_t t;
        t.rst_n = r;  t.ack = a;  t.rdata = rd;  t.ready = rdy;  t.new_pc = np[29:0];
        t.e_pc = epc[29:0];  t.e_req = ereq;  t.e_inst = einst;  t.e_valid = evld;
        t.e_err = eerr;  t.e_cnt = ecnt;
        tbl.push_back(t);
    endtask

    task automatic check_all(input string tag, input int idx, input vec_t t);
        chk({tag, ".pc"},          idx, {2'b0, pc},             {2'b0, t.e_pc});
        chk({tag, ".imem_req"},    idx, {31'b0, imem_req},      {31'b0, t.e_req});
        chk({tag, ".inst"},        idx, inst,                   t.e_inst);
        chk({tag, ".inst_valid"},  idx, {31'b0, inst_valid},    {31'b0, t.e_valid});
        chk({tag, ".fetch_err"},   idx, {31'b0, fetch_err},     {31'b0, t.e_err});
        chk({tag, ".fetch_count"}, idx, fetch_count,            t.e_cnt);
    endtask

    initial begin
        logic [31:0] last;
        vec_t        t;

        // reset held 3 cycles, then IDLE for one cycle, then REQ
        for (int i = 0; i < 3; i++) v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        v(1, 1, 32'h2001_0005, 0, 0, 0, 0, 32'h2001_0005, 1, 0, 0);
        // sequential stream, best-case 2 cycles per instruction
        last = 32'h2001_0005;
        for (int i = 1; i <= 4; i++) begin
            v(1, 0, 0, 1, i, i, 1, last, 0, 0, i);
            last = 32'hA000_0000 + i;
            v(1, 1, last, 0, 0, i, 0, last, 1, 0, i);
        end
        // decode stall with changing new_pc and stray acks
        for (int j = 0; j < 5; j++) v(1, 1, 32'hDEAD_BEEF, 0, j * 16 + 3, 4, 0, last, 1, 0, 4);
        v(1, 0, 0, 1, 32'h40, 32'h40, 1, last, 0, 0, 5);
        // ack delayed 7 cycles; ready during REQ ignored
        for (int j = 0; j < 7; j++) v(1, 0, 0, 1, 32'h99, 32'h40, 1, last, 0, 0, 5);
        v(1, 1, 32'h0000_00B7, 0, 0, 32'h40, 0, 32'h0000_00B7, 1, 0, 5);
        v(1, 0, 0, 1, 32'h50, 32'h50, 1, 32'h0000_00B7, 0, 0, 6);
        // ack in the 16th REQ cycle still captures
        for (int j = 0; j < 15; j++) v(1, 0, 0, 0, 0, 32'h50, 1, 32'h0000_00B7, 0, 0, 6);
        v(1, 1, 32'h0000_0C16, 0, 0, 32'h50, 0, 32'h0000_0C16, 1, 0, 6);
        // pc at top of range then new_pc=0 is captured as given
        v(1, 0, 0, 1, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 1, 32'h0000_0C16, 0, 0, 7);
        v(1, 1, 32'h0000_00D0, 0, 0, 32'h3FFF_FFFF, 0, 32'h0000_00D0, 1, 0, 7);
        v(1, 0, 0, 1, 0, 0, 1, 32'h0000_00D0, 0, 0, 8);
        v(1, 1, 32'h0000_00E0, 0, 0, 0, 0, 32'h0000_00E0, 1, 0, 8);
        v(1, 0, 0, 1, 7, 7, 1, 32'h0000_00E0, 0, 0, 9);
        // 16 cycles without ack -> ERR, late ack and ready ignored
        for (int j = 0; j < 15; j++) v(1, 0, 0, 0, 0, 7, 1, 32'h0000_00E0, 0, 0, 9);
        v(1, 0, 0, 0, 0, 7, 0, 32'h0000_00E0, 0, 1, 9);
        for (int j = 0; j < 2; j++) v(1, 1, 32'h0000_00F0, 1, 9, 7, 0, 32'h0000_00E0, 0, 1, 9);
        // reset clears the error
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // reset in REQ with ack present: ack ignored
        v(0, 1, 32'h0000_00FF, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n = tbl[i].rst_n;  imem_ack = tbl[i].ack;  imem_rdata = tbl[i].rdata;
            inst_ready = tbl[i].ready;  new_pc = tbl[i].new_pc;
            @(posedge clk);
            #1;
            check_all("vec", i, tbl[i]);
        end

        // fetch_count wrap: preload via force while stalled in OUT, then hand off
        @(negedge clk);
        imem_ack = 1'b1;  imem_rdata = 32'h1234_5678;  inst_ready = 1'b0;
        @(posedge clk);
        #1;
        t = '{1'b1, 1'b0, 32'h0, 1'b0, 30'h0, 30'h0, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 32'h0};
        check_all("wrap_cap", 0, t);
        @(negedge clk);
        imem_ack = 1'b0;
        force dut.fetch_count = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        chk("wrap_preload", 0, fetch_count, 32'hFFFF_FFFF);
        @(negedge clk);
        release dut.fetch_count;
        inst_ready = 1'b1;  new_pc = 30'h5;
        @(posedge clk);
        #1;
        t = '{1'b1, 1'b0, 32'h0, 1'b0, 30'h0, 30'h5, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0};
        check_all("wrap_hs", 0, t);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
